// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial data, control strobes and match status.
// Define SEQ_DET_MASK_EN to add the mask_in don't-care pattern signal.
interface seq_detector_param_if #(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned FW = $clog2(SEQ_LEN + 1);

  logic               x;
  logic               en;
  logic               load;
  logic [SEQ_LEN-1:0] pat_in;
  logic               overlap;
  logic               clr_cnt;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic [FW-1:0]      fill;
`ifdef SEQ_DET_MASK_EN
  logic [SEQ_LEN-1:0] mask_in;
`endif

  modport master (
`ifdef SEQ_DET_MASK_EN
    output mask_in,
`endif
    output x, en, load, pat_in, overlap, clr_cnt,
    input  z, match_cnt, fill
  );

  modport slave (
`ifdef SEQ_DET_MASK_EN
    input  mask_in,
`endif
    input  x, en, load, pat_in, overlap, clr_cnt,
    output z, match_cnt, fill
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loadable SEQ_LEN-bit pattern with overlap control and
// saturating match counter. Define SEQ_DET_MASK_EN for per-bit don't-care masking.
module seq_detector_param #(
  parameter int unsigned        SEQ_LEN  = 4,
  parameter int unsigned        CNT_W    = 8,
  parameter logic [SEQ_LEN-1:0] PAT_INIT = SEQ_LEN'(4'b1101)
) (
  input  logic                 clk_o,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int unsigned   FW   = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist_q, hist_d, pat_q, diff;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic               z_q, hit;
`ifdef SEQ_DET_MASK_EN
  logic [SEQ_LEN-1:0] mask_q;
`endif

  always_comb begin
    hist_d = {hist_q[SEQ_LEN-2:0], bus.x};
    fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
`ifdef SEQ_DET_MASK_EN
    diff   = (hist_d ^ pat_q) & mask_q;
`else
    diff   = hist_d ^ pat_q;
`endif
    // fill gate keeps pre-load/pre-reset zeros from matching an all-zero pattern
    hit      = !bus.load && bus.en && (fill_d == FULL) && (diff == '0);
    cnt_base = bus.clr_cnt ? '0 : cnt_q;
    cnt_d    = (hit && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
  end

  always_ff @(posedge clk_o or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      z_q    <= 1'b0;
      cnt_q  <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q <= '1;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (bus.load) begin
        pat_q  <= bus.pat_in;
        hist_q <= '0;
        fill_q <= '0;
        z_q    <= 1'b0;
`ifdef SEQ_DET_MASK_EN
        mask_q <= bus.mask_in;
`endif
      end else if (bus.en) begin
        z_q <= hit;
        if (hit && !bus.overlap) begin
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= hist_d;
          fill_q <= fill_d;
        end
      end else begin
        z_q <= 1'b0;
      end
    end
  end

  assign bus.z         = z_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial sequence detector with a runtime-programmable pattern of SEQ_LEN bits. It supports overlapping and non-overlapping match modes, an input-enable qualifier and a saturating match counter. It sits behind the debouncer and is clocked by the debounced clock clk_o. It replaces fixed-pattern hand-derived FSM detectors in the design.

Parameters:
SEQ_LEN, 4, pattern length in bits (2..16)
CNT_W, 8, width of match counter
PAT_INIT, 4'b1101, pattern value loaded at reset (SEQ_LEN bits)

Ports:
clk_o  input  1  debounced clock, rising-edge active
reset  input  1  asynchronous, active-low reset
x  input  1  serial data bit, sampled on rising clk_o when en=1
en  input  1  sample qualifier; en=0 freezes history, fill and counter
load  input  1  pattern load strobe
pat_in  input  SEQ_LEN  new pattern; bit SEQ_LEN-1 = first bit received, bit 0 = last
overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match
clr_cnt  input  1  synchronous clear of match_cnt
z  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches
fill  output  clog2(SEQ_LEN+1)  number of valid history bits

Behaviour:
- Reset: clock clk_o; reset is asynchronous and active-low (reset=0 resets).
  - hist=0, fill=0, pat_q=PAT_INIT, z=0, match_cnt=0.
  - Deasserting reset is synchronised by the integrator and is not handled in this block.
- State:
  - hist[SEQ_LEN-1:0] is a shift register; the newest bit enters hist[0].
  - fill counts valid bits and saturates at SEQ_LEN; it acts as the FSM state (0..SEQ_LEN).
- Priority per rising edge: load > en. clr_cnt is independent.
- load=1:
  - pat_q<=pat_in, hist<=0, fill<=0, z<=0.
  - x is not sampled on that edge. match_cnt is unaffected unless clr_cnt=1.
- load=0, en=1:
  - nh = {hist[SEQ_LEN-2:0], x}; nf = min(fill+1, SEQ_LEN).
  - hit = (nf==SEQ_LEN) && (nh==pat_q).
  - z<=hit.
  - hit and overlap=1: hist<=nh, fill<=SEQ_LEN.
  - hit and overlap=0: hist<=0, fill<=0.
  - no hit: hist<=nh, fill<=nf.
- load=0, en=0: hist and fill hold; z<=0.
- z behaviour:
  - z is high for exactly one clk_o cycle, starting on the edge that samples the final pattern bit.
  - There is no combinational path from x to z.
- match_cnt:
  - Increments on every hit and saturates at 2^CNT_W-1.
  - clr_cnt=1 sets it to 0. If clr_cnt=1 and hit occur on the same edge, the result is 1 (the hit counts after the clear).
- Stale history never matches: an all-zero pattern requires SEQ_LEN zeros sampled after reset or load.
- overlap is sampled on each edge and may change between bits; it takes effect on the edge it is sampled.
- Reset mid-sequence discards partial progress immediately.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds port mask_in (input, SEQ_LEN) and register mask_q (reset value all-ones).
  - mask_q is loaded from mask_in alongside pat_q on load.
  - hit uses ((nh ^ pat_q) & mask_q)==0; a 0 bit in mask_q is don't-care. The fill requirement is unchanged.
- Undefined:
  - No mask port or register; exact compare only.

Test Plan:
- SEQ_LEN=4, pattern 1101, overlap=1, en=1, stream 1,1,0,1,1,0,1 -> z high after bits 4 and 7 only; match_cnt=2; fill=4 after bit 7.
- Same stream, overlap=0 -> z high after bit 4 only; match_cnt=1; fill=3 after bit 7.
- load pattern 0000 right after reset, feed 0,0,0 -> z=0 and fill=3; 4th 0 -> z=1; 5th 0 (overlap=1) -> z=1 again.
- Pattern 1101, feed 1,1,0, then assert reset low for 1 cycle, release, feed 1 -> z=0, fill=1, match_cnt=0.
- Pattern 1101, stream 1,1,(en=0 with x=1 for 3 cycles),0,1 -> z=1 only on the final edge; the en=0 cycles cause no shift.
- CNT_W=2, overlap=1, pattern 1111, feed 8 ones -> match_cnt rises 1,2,3 and stays 3. Then clr_cnt=1 coincident with a hit -> match_cnt=1.
